// File: rtl/ps2_tone_map.sv
// ps2_tone_map: turns a decoded PS/2 set-2 scan-code byte stream into a beeper tone
//   (half-period count + one-cycle new-note strobe + currently held make code).
// Latency: one cycle from the sampled make byte to key_flag/cnt_freq/key_code.
// Backpressure: none; every ps2_byte_valid cycle is consumed as exactly one byte.
// Ports: sys_clk, sys_rst_n (async active-low), ps2_byte[7:0], ps2_byte_valid,
//   cnt_freq[31:0], key_flag, key_code[7:0].
// Optional build macro UPPER_OCTAVE_EN: also map the Q..U row one octave up.
module ps2_tone_map #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int PREFIX_TIMEOUT = 50_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  ps2_byte,
  input  logic        ps2_byte_valid,
  output logic [31:0] cnt_freq,
  output logic        key_flag,
  output logic [7:0]  key_code
);

  localparam int TW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(PREFIX_TIMEOUT - 1);

  // Half-period counts, floor(CLK_FREQ / (2*f)), fixed at elaboration.
  localparam logic [31:0] CNT_C = 32'(CLK_FREQ / (2 * 262));
  localparam logic [31:0] CNT_D = 32'(CLK_FREQ / (2 * 294));
  localparam logic [31:0] CNT_E = 32'(CLK_FREQ / (2 * 330));
  localparam logic [31:0] CNT_F = 32'(CLK_FREQ / (2 * 349));
  localparam logic [31:0] CNT_G = 32'(CLK_FREQ / (2 * 392));
  localparam logic [31:0] CNT_A = 32'(CLK_FREQ / (2 * 440));
  localparam logic [31:0] CNT_B = 32'(CLK_FREQ / (2 * 494));

  localparam logic [7:0] BYTE_BRK = 8'hF0;
  localparam logic [7:0] BYTE_EXT = 8'hE0;

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] to_cnt, to_cnt_nxt;
  logic          map_hit;
  logic [31:0]   map_cnt;
  logic [31:0]   cnt_freq_nxt;
  logic [7:0]    key_code_nxt;
  logic          key_flag_nxt;

  // Make-code lookup; the upper row is the lower-octave count halved.
  always_comb begin
    map_hit = 1'b1;
    map_cnt = '0;
    case (ps2_byte)
      8'h1C: map_cnt = CNT_C;
      8'h1B: map_cnt = CNT_D;
      8'h23: map_cnt = CNT_E;
      8'h2B: map_cnt = CNT_F;
      8'h34: map_cnt = CNT_G;
      8'h33: map_cnt = CNT_A;
      8'h3B: map_cnt = CNT_B;
`ifdef UPPER_OCTAVE_EN
      8'h15: map_cnt = CNT_C >> 1;
      8'h1D: map_cnt = CNT_D >> 1;
      8'h24: map_cnt = CNT_E >> 1;
      8'h2D: map_cnt = CNT_F >> 1;
      8'h2C: map_cnt = CNT_G >> 1;
      8'h35: map_cnt = CNT_A >> 1;
      8'h3C: map_cnt = CNT_B >> 1;
`else
`endif
      default: map_hit = 1'b0;
    endcase
  end

  // State register, timeout counter and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      to_cnt   <= '0;
      cnt_freq <= '0;
      key_flag <= 1'b0;
      key_code <= 8'h00;
    end else begin
      state    <= state_nxt;
      to_cnt   <= to_cnt_nxt;
      cnt_freq <= cnt_freq_nxt;
      key_flag <= key_flag_nxt;
      key_code <= key_code_nxt;
    end
  end

  // Next-state: prefix tracking plus prefix abandonment on timeout.
  always_comb begin
    state_nxt = state;
    if (ps2_byte_valid) begin
      case (state)
        IDLE: begin
          if (ps2_byte == BYTE_BRK)      state_nxt = BRK;
          else if (ps2_byte == BYTE_EXT) state_nxt = EXT;
        end
        EXT: begin
          if (ps2_byte == BYTE_BRK)      state_nxt = EXT_BRK;
          else if (ps2_byte != BYTE_EXT) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;  // BRK / EXT_BRK consume one byte
      endcase
    end else if (state != IDLE && to_cnt == TO_LAST) begin
      // A byte in the expiry cycle takes the branch above, so it still
      // sees the prefix.
      state_nxt = IDLE;
    end
    // Counter only runs while a prefix waits without a byte; it never passes
    // TO_LAST because reaching it forces IDLE on the next idle cycle.
    if (ps2_byte_valid || state_nxt == IDLE) to_cnt_nxt = '0;
    else                                     to_cnt_nxt = to_cnt + TW'(1);
  end

  // Output: make/repeat/break handling on the registered outputs.
  always_comb begin
    cnt_freq_nxt = cnt_freq;
    key_code_nxt = key_code;
    key_flag_nxt = 1'b0;
    if (ps2_byte_valid) begin
      case (state)
        IDLE: begin
          // Repeat of the held key (typematic) must not retrigger the note.
          if (map_hit && ps2_byte != key_code) begin
            cnt_freq_nxt = map_cnt;
            key_code_nxt = ps2_byte;
            key_flag_nxt = 1'b1;
          end
        end
        BRK: begin
          // Releasing a key that was already superseded leaves the new one held.
          if (ps2_byte == key_code) key_code_nxt = 8'h00;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_tone_map.sv
module tb_ps2_tone_map;

  localparam int CLK_HZ = 50_000_000;
  localparam int P      = 200;   // shortened prefix timeout keeps the run brief

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [7:0]  ps2_byte = 8'h00;
  logic        ps2_byte_valid = 1'b0;
  logic [31:0] cnt_freq;
  logic        key_flag;
  logic [7:0]  key_code;

  int checks = 0;
  int errors = 0;

  ps2_tone_map #(.CLK_FREQ(CLK_HZ), .PREFIX_TIMEOUT(P)) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .ps2_byte       (ps2_byte),
    .ps2_byte_valid (ps2_byte_valid),
    .cnt_freq       (cnt_freq),
    .key_flag       (key_flag),
    .key_code       (key_code)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // key_flag must never stay high for two consecutive cycles.
  logic prev_flag = 1'b0;
  always @(negedge sys_clk) begin
    if (prev_flag === 1'b1) begin
      checks++;
      if (key_flag !== 1'b0) begin
        errors++;
        $display("FAIL flag_width: key_flag high for two cycles, got %b expected 0", key_flag);
      end
    end
    prev_flag = key_flag;
  end

  // Present one byte for one cycle; return with the DUT's response visible.
  task automatic drive_byte(input logic [7:0] b);
    @(negedge sys_clk);
    ps2_byte       = b;
    ps2_byte_valid = 1'b1;
    @(negedge sys_clk);
    ps2_byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // ---------------- reference model ----------------
  function automatic int base_hz(input logic [7:0] c);
    case (c)
      8'h1C: return 262;
      8'h1B: return 294;
      8'h23: return 330;
      8'h2B: return 349;
      8'h34: return 392;
      8'h33: return 440;
      8'h3B: return 494;
      default: return 0;
    endcase
  endfunction

  // Returns 0 for an unmapped byte (every real count is nonzero).
  function automatic logic [31:0] note_cnt(input logic [7:0] c);
    logic [7:0] low;
    if (base_hz(c) != 0) return 32'(CLK_HZ / (2 * base_hz(c)));
    low = 8'h00;
`ifdef UPPER_OCTAVE_EN
    case (c)
      8'h15: low = 8'h1C;
      8'h1D: low = 8'h1B;
      8'h24: low = 8'h23;
      8'h2D: low = 8'h2B;
      8'h2C: low = 8'h34;
      8'h35: low = 8'h33;
      8'h3C: low = 8'h3B;
      default: low = 8'h00;
    endcase
`endif
    if (low == 8'h00) return 32'd0;
    return 32'(CLK_HZ / (2 * base_hz(low))) >> 1;
  endfunction

  bit          m_brk, m_ext, m_flag;
  logic [7:0]  m_code;
  logic [31:0] m_cnt;

  // age: cycles since the previous byte (gap + 1).
  task automatic model_step(input logic [7:0] b, input int age);
    m_flag = 1'b0;
    if ((m_brk || m_ext) && age > P) begin
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
    if (m_brk && m_ext) begin
      m_brk = 1'b0;
      m_ext = 1'b0;
    end else if (m_brk) begin
      if (b == m_code) m_code = 8'h00;
      m_brk = 1'b0;
    end else if (m_ext) begin
      if (b == 8'hF0)      m_brk = 1'b1;
      else if (b != 8'hE0) m_ext = 1'b0;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (note_cnt(b) != 0 && b != m_code) begin
      m_code = b;
      m_cnt  = note_cnt(b);
      m_flag = 1'b1;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic [7:0]  b;
    logic [31:0] gap;
    logic        flag;
    logic [31:0] cnt;
    logic [7:0]  code;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] b, input int gap, input logic flag,
                     input logic [31:0] cnt, input logic [7:0] code);
    vec_t v;
    v.b = b; v.gap = 32'(gap); v.flag = flag; v.cnt = cnt; v.code = code;
    vecs.push_back(v);
  endtask

  logic [7:0] pool [19];

  initial begin
    int age;
    logic [7:0] b;
    int gap;
    int r;

    // Typematic, make/break, extended prefixes, unmapped bytes.
    add(8'h1C, 3, 1, 95419, 8'h1C);
    add(8'h1C, 3, 0, 95419, 8'h1C);
    add(8'h1C, 3, 0, 95419, 8'h1C);
    add(8'h33, 3, 1, 56818, 8'h33);
    add(8'hF0, 3, 0, 56818, 8'h33);
    add(8'h33, 3, 0, 56818, 8'h00);
    add(8'h33, 3, 1, 56818, 8'h33);
    add(8'hE0, 3, 0, 56818, 8'h33);
    add(8'h1C, 3, 0, 56818, 8'h33);
    add(8'hE0, 3, 0, 56818, 8'h33);
    add(8'hF0, 3, 0, 56818, 8'h33);
    add(8'h1C, 3, 0, 56818, 8'h33);
    add(8'h2B, 3, 1, 71633, 8'h2B);
    add(8'hAA, 3, 0, 71633, 8'h2B);
    add(8'hFA, 3, 0, 71633, 8'h2B);
    add(8'hEE, 3, 0, 71633, 8'h2B);
    add(8'h1B, 3, 1, 85034, 8'h1B);
    add(8'hF0, 3, 0, 85034, 8'h1B);
    add(8'h2B, 3, 0, 85034, 8'h1B);   // break of a key no longer held
`ifdef UPPER_OCTAVE_EN
    add(8'h15, 3, 1, 47709, 8'h15);
`else
    add(8'h15, 3, 0, 85034, 8'h1B);
`endif
    add(8'h3B, 3, 1, 50607, 8'h3B);
    add(8'h34, 3, 1, 63775, 8'h34);
    add(8'h23, 3, 1, 75757, 8'h23);
    // Prefix timeout boundaries: age P still pending, age P+1 abandoned.
    add(8'hF0, P,     0, 75757, 8'h23);
    add(8'h1C, 3,     1, 95419, 8'h1C);
    add(8'hF0, P - 1, 0, 95419, 8'h1C);
    add(8'h1C, 3,     0, 95419, 8'h00);
    add(8'hE0, P,     0, 95419, 8'h00);
    add(8'h1B, 3,     1, 85034, 8'h1B);
    add(8'hE0, 2,     0, 85034, 8'h1B);
    add(8'hF0, P,     0, 85034, 8'h1B);
    add(8'h23, 3,     1, 75757, 8'h23);
    add(8'hE0, P - 1, 0, 75757, 8'h23);
    add(8'hF0, 3,     0, 75757, 8'h23);
    add(8'h1B, 3,     0, 75757, 8'h23);
    // E0 after F0 is just the break byte, not a new prefix.
    add(8'hF0, 3, 0, 75757, 8'h23);
    add(8'hE0, 3, 0, 75757, 8'h23);
    add(8'h1C, 1, 1, 95419, 8'h1C);

    // Reset state.
    idle(3);
    check("rst_cnt_freq", cnt_freq, 32'd0);
    check("rst_key_flag", 32'(key_flag), 32'd0);
    check("rst_key_code", 32'(key_code), 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    idle(2);

    foreach (vecs[i]) begin
      drive_byte(vecs[i].b);
      check($sformatf("vec%0d_flag", i), 32'(key_flag), 32'(vecs[i].flag));
      check($sformatf("vec%0d_cnt",  i), cnt_freq, vecs[i].cnt);
      check($sformatf("vec%0d_code", i), 32'(key_code), 32'(vecs[i].code));
      idle(int'(vecs[i].gap) - 1);
    end

    // Reset in the middle of a break: next byte must be seen from IDLE.
    drive_byte(8'hF0);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check("midrst_cnt_freq", cnt_freq, 32'd0);
    check("midrst_key_code", 32'(key_code), 32'd0);
    check("midrst_key_flag", 32'(key_flag), 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    idle(1);
    drive_byte(8'h1C);
    check("midrst_make_flag", 32'(key_flag), 32'd1);
    check("midrst_make_cnt",  cnt_freq, 32'd95419);
    check("midrst_make_code", 32'(key_code), 32'h1C);
    idle(2);

    // Randomized traffic against the model.
    m_brk = 1'b0; m_ext = 1'b0; m_flag = 1'b0;
    m_code = 8'h1C; m_cnt = 32'd95419;
    pool = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B,
             8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C,
             8'hF0, 8'hE0, 8'hAA, 8'hFA, 8'hEE};
    age = 3;
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      b = 8'($urandom_range(0, 255));
      else if (r <= 2) b = 8'hF0;
      else             b = pool[$urandom_range(0, 18)];
      r = int'($urandom_range(0, 19));
      if (r == 0)      gap = P - 1;
      else if (r == 1) gap = P;
      else if (r == 2) gap = P + 1;
      else             gap = int'($urandom_range(1, 4));
      model_step(b, age);
      drive_byte(b);
      check($sformatf("rnd%0d_flag", n), 32'(key_flag), 32'(m_flag));
      check($sformatf("rnd%0d_cnt",  n), cnt_freq, m_cnt);
      check($sformatf("rnd%0d_code", n), 32'(key_code), 32'(m_code));
      idle(gap - 1);
      age = gap + 1;
    end

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
